// File: rtl/jpeg_quant_pkg.sv
// jpeg_quant_pkg: standard Q tables, reciprocal tables, enums and
// the saturate helper shared by the jpeg_quant_pipe slice.
package jpeg_quant_pkg;

  typedef enum logic {
    TBL_LUMA   = 1'b0,
    TBL_CHROMA = 1'b1
  } tbl_e;

  typedef enum logic {
    MODE_QUANT   = 1'b0,
    MODE_DEQUANT = 1'b1
  } mode_e;

  typedef logic [0:63][7:0]  qtbl_t;
  typedef logic [0:63][31:0] rtbl_t;

  localparam int RECIP_FRAC_STD = 16;

  localparam qtbl_t LUMA_Q = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  localparam qtbl_t CHROMA_Q = {
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  // round(2^frac / q), evaluated at elaboration only
  function automatic rtbl_t mk_recip(qtbl_t q, int frac);
    rtbl_t r;
    for (int i = 0; i < 64; i++) begin
      r[i] = ((32'd1 << frac) + 32'(q[i] >> 1)) / 32'(q[i]);
    end
    return r;
  endfunction

  localparam rtbl_t LUMA_RECIP   = mk_recip(LUMA_Q, RECIP_FRAC_STD);
  localparam rtbl_t CHROMA_RECIP = mk_recip(CHROMA_Q, RECIP_FRAC_STD);

  function automatic logic signed [63:0] sat(
    logic signed [63:0] v,
    int w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/jpeg_quant_table.sv
// jpeg_quant_table: Q/RECIP storage with registered lookup.
// JPEG_QUANT_TABLE_LOAD_EN adds writable tables and a serial divider.
module jpeg_quant_table
  import jpeg_quant_pkg::*;
#(
  parameter int RECIP_FRAC = 16,
  parameter int RW = RECIP_FRAC + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          tbl,
  input  logic [5:0]    idx,
  output logic [7:0]    q,
  output logic [RW-1:0] recip
`ifdef JPEG_QUANT_TABLE_LOAD_EN
  ,
  input  logic          tbl_we,
  input  logic          tbl_sel,
  input  logic [5:0]    tbl_addr,
  input  logic [7:0]    tbl_q,
  output logic          tbl_busy
`endif
);

  localparam rtbl_t LUMA_R   = mk_recip(LUMA_Q, RECIP_FRAC);
  localparam rtbl_t CHROMA_R = mk_recip(CHROMA_Q, RECIP_FRAC);

`ifdef JPEG_QUANT_TABLE_LOAD_EN

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_DIV  = 1'b1;
  localparam int   CW      = $clog2(RW);

  logic                       st;
  logic [CW-1:0]              cnt;
  logic [7:0]                 rem;
  logic [7:0]                 rem_n;
  logic [8:0]                 r2;
  logic                       ge;
  logic [RW-1:0]              dvd;
  logic [RW-1:0]              quo;
  logic [RW-1:0]              quo_n;
  logic                       w_sel;
  logic [5:0]                 w_addr;
  logic [7:0]                 w_q;
  logic [1:0][0:63][7:0]      q_mem;
  logic [1:0][0:63][RW-1:0]   r_mem;

  assign tbl_busy = (st == ST_DIV);

  // restoring divide of (2^frac + q/2) by q, one quotient bit per cycle
  always_comb begin
    r2    = {rem, dvd[RW-1]};
    ge    = (r2 >= {1'b0, w_q});
    rem_n = ge ? 8'(r2 - {1'b0, w_q}) : r2[7:0];
    quo_n = {quo[RW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      quo    <= '0;
      w_sel  <= 1'b0;
      w_addr <= '0;
      w_q    <= '0;
      q      <= '0;
      recip  <= '0;
      for (int i = 0; i < 64; i++) begin
        q_mem[0][i] <= LUMA_Q[i];
        q_mem[1][i] <= CHROMA_Q[i];
        r_mem[0][i] <= LUMA_R[i][RW-1:0];
        r_mem[1][i] <= CHROMA_R[i][RW-1:0];
      end
    end else begin
      if (en) begin
        q     <= q_mem[tbl][idx];
        recip <= r_mem[tbl][idx];
      end
      unique case (1'b1)
        (st == ST_IDLE && tbl_we): begin
          w_sel  <= tbl_sel;
          w_addr <= tbl_addr;
          w_q    <= tbl_q;
          dvd    <= (RW'(1) << RECIP_FRAC) + RW'(tbl_q >> 1);
          rem    <= '0;
          quo    <= '0;
          cnt    <= '0;
          st     <= ST_DIV;
        end
        (st == ST_DIV): begin
          rem <= rem_n;
          dvd <= dvd << 1;
          quo <= quo_n;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(RW - 1)) begin
            q_mem[w_sel][w_addr] <= w_q;
            r_mem[w_sel][w_addr] <= quo_n;
            st                   <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

`else

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      recip <= '0;
    end else if (en) begin
      q     <= tbl ? CHROMA_Q[idx] : LUMA_Q[idx];
      recip <= tbl ? CHROMA_R[idx][RW-1:0] : LUMA_R[idx][RW-1:0];
    end
  end

`endif

endmodule

// File: rtl/jpeg_quant_pipe.sv
// jpeg_quant_pipe: 3-stage streaming 8x8 quantiser/dequantiser.
// Optional JPEG_QUANT_TABLE_LOAD_EN exposes runtime table writes.
module jpeg_quant_pipe
  import jpeg_quant_pkg::*;
#(
  parameter int COEF_W     = 12,
  parameter int OUT_W      = 12,
  parameter int RECIP_FRAC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  input  logic              in_chroma,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [5:0]        out_idx,
  output logic              out_last
`ifdef JPEG_QUANT_TABLE_LOAD_EN
  ,
  input  logic              tbl_we,
  input  logic              tbl_sel,
  input  logic [5:0]        tbl_addr,
  input  logic [7:0]        tbl_q,
  output logic              tbl_busy
`endif
);

  localparam int RW = RECIP_FRAC + 1;
  localparam int PW = COEF_W + RECIP_FRAC + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (RECIP_FRAC - 1);

  logic                     en;
  logic                     acc;
  logic [5:0]               idx;
  tbl_e                     blk_tbl;
  tbl_e                     cur_tbl;
  mode_e                    blk_mode;
  mode_e                    cur_mode;
  logic [7:0]               tq;
  logic [RW-1:0]            trecip;

  logic                     s0_valid;
  logic [COEF_W-1:0]        s0_data;
  logic [5:0]               s0_idx;
  mode_e                    s0_mode;

  logic                     s1_valid;
  logic [5:0]               s1_idx;
  mode_e                    s1_mode;
  logic signed [PW-1:0]     s1_prod;

  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     mag_abs;
  logic signed [PW-1:0]     mag;
  logic signed [PW-1:0]     rnd;
  logic signed [63:0]       sv;
  logic [OUT_W-1:0]         sat_v;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;

  // first beat of a block uses the live selects, later beats the latched ones
  assign cur_tbl  = (idx == 6'd0) ? tbl_e'(in_chroma) : blk_tbl;
  assign cur_mode = (idx == 6'd0) ? mode_e'(in_mode) : blk_mode;

  jpeg_quant_table #(
    .RECIP_FRAC (RECIP_FRAC),
    .RW         (RW)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .tbl      (cur_tbl),
    .idx      (idx),
    .q        (tq),
    .recip    (trecip)
`ifdef JPEG_QUANT_TABLE_LOAD_EN
    ,
    .tbl_we   (tbl_we),
    .tbl_sel  (tbl_sel),
    .tbl_addr (tbl_addr),
    .tbl_q    (tbl_q),
    .tbl_busy (tbl_busy)
`endif
  );

  always_comb begin
    if (s0_mode == MODE_DEQUANT) begin
      prod = PW'($signed(s0_data)) * PW'($signed({1'b0, tq}));
    end else begin
      prod = PW'($signed(s0_data)) * PW'($signed({1'b0, trecip}));
    end
  end

  // round half away from zero on the magnitude, then restore sign
  always_comb begin
    mag_abs = s1_prod[PW-1] ? -s1_prod : s1_prod;
    mag     = (mag_abs + HALF) >>> RECIP_FRAC;
    rnd     = s1_prod[PW-1] ? -mag : mag;
    sv      = (s1_mode == MODE_DEQUANT) ? 64'(s1_prod) : 64'(rnd);
    sat_v   = OUT_W'(sat(sv, OUT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      blk_tbl   <= TBL_LUMA;
      blk_mode  <= MODE_QUANT;
      s0_valid  <= 1'b0;
      s0_data   <= '0;
      s0_idx    <= '0;
      s0_mode   <= MODE_QUANT;
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_mode   <= MODE_QUANT;
      s1_prod   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (acc) begin
        idx <= idx + 6'd1;
        if (idx == 6'd0) begin
          blk_tbl  <= cur_tbl;
          blk_mode <= cur_mode;
        end
      end
      if (en) begin
        s0_valid  <= in_valid;
        s0_data   <= in_data;
        s0_idx    <= idx;
        s0_mode   <= cur_mode;
        s1_valid  <= s0_valid;
        s1_idx    <= s0_idx;
        s1_mode   <= s0_mode;
        s1_prod   <= prod;
        out_valid <= s1_valid;
        out_data  <= sat_v;
        out_idx   <= s1_idx;
        out_last  <= (s1_idx == 6'd63);
      end
    end
  end

endmodule
